// File: rtl/stoch_num_gen.sv
// Stochastic number generator: turns a held binary operand into a Bernoulli
// bitstream by comparing it against an external random word every cycle.
module stoch_num_gen #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 16
) (
   input  logic             TRIG,
   input  logic             RESET,
   input  logic             START,
   input  logic [WIDTH-1:0] VALUE,
   input  logic [LEN_W-1:0] LENGTH,
   input  logic [WIDTH-1:0] RND,
   output logic             SN,
   output logic             SN_VALID,
   output logic             BUSY,
   output logic             DONE,
   output logic [LEN_W-1:0] ONES_CNT,
   output logic [1:0]       DBG_STATE
);

   // Handshake: START is a request honoured only in IDLE (no queuing);
   // SN_VALID qualifies SN for one cycle per stream bit, with no back-pressure.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] val_q;
   logic [LEN_W-1:0] cnt_q;
   logic [LEN_W-1:0] ones_q;
   logic             sn_q;
   logic             sn_valid_q;
   logic             busy_q;
   logic             done_q;
   logic             hit_d;

   assign hit_d = (RND < val_q);

   always_ff @(posedge TRIG or negedge RESET) begin
      if (!RESET) begin
         state_q    <= IDLE;
         val_q      <= '0;
         cnt_q      <= '0;
         ones_q     <= '0;
         sn_q       <= 1'b0;
         sn_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               sn_q       <= 1'b0;
               sn_valid_q <= 1'b0;
               done_q     <= 1'b0;
               if (START) begin
                  val_q  <= VALUE;
                  cnt_q  <= LENGTH;
                  ones_q <= '0;
                  // A zero-length request skips straight to the end-of-stream pulse.
                  if (LENGTH != '0) begin
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= FIN;
                     busy_q  <= 1'b0;
                  end
               end
            end
            RUN: begin
               sn_q       <= hit_d;
               sn_valid_q <= 1'b1;
               cnt_q      <= cnt_q - LEN_W'(1);
               ones_q     <= ones_q + LEN_W'(hit_d);
               if (cnt_q == LEN_W'(1)) begin
                  state_q <= FIN;
                  busy_q  <= 1'b0;
               end
            end
            FIN: begin
               sn_q       <= 1'b0;
               sn_valid_q <= 1'b0;
               done_q     <= 1'b1;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
            end
            default: begin
               state_q    <= IDLE;
               sn_q       <= 1'b0;
               sn_valid_q <= 1'b0;
               busy_q     <= 1'b0;
               done_q     <= 1'b0;
            end
         endcase
      end
   end

   assign SN        = sn_q;
   assign SN_VALID  = sn_valid_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign ONES_CNT  = ones_q;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_stoch_num_gen.sv
// Bench for stoch_num_gen: directed streams with a queue of expected stream
// bits, checked by a negedge monitor, plus end-of-stream and reset checks.
module tb_stoch_num_gen;

   logic        trig;
   logic        rst_n;
   logic        start;
   logic [7:0]  value;
   logic [15:0] length;
   logic [7:0]  rnd;
   logic        sn;
   logic        sn_valid;
   logic        busy;
   logic        done;
   logic [15:0] ones_cnt;
   logic [1:0]  dbg_state;

   int          pass_cnt  = 0;
   int          total_cnt = 0;
   int          done_cnt  = 0;
   int          valid_cnt = 0;
   logic [0:0]  exp_q[$];
   logic        rec = 1'b0;
   logic        sn_log[$];
   logic        sn_ref[$];
   logic [7:0]  lfsr;

   stoch_num_gen #(.WIDTH(8), .LEN_W(16)) dut (
      .TRIG      (trig),
      .RESET     (rst_n),
      .START     (start),
      .VALUE     (value),
      .LENGTH    (length),
      .RND       (rnd),
      .SN        (sn),
      .SN_VALID  (sn_valid),
      .BUSY      (busy),
      .DONE      (done),
      .ONES_CNT  (ones_cnt),
      .DBG_STATE (dbg_state)
   );

   // clock / reset
   initial trig = 1'b0;
   always #5 trig = ~trig;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // scoreboard monitor: pops one expected bit per valid stream bit
   always @(negedge trig) begin
      if (sn_valid) begin
         valid_cnt++;
         if (rec) sn_log.push_back(sn);
         if (exp_q.size() == 0) check("sn_extra", 32'd1, 32'd0);
         else check("sn_bit", {31'd0, sn}, {31'd0, exp_q.pop_front()});
      end
      if (done) done_cnt++;
   end

   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
   endfunction

   // mode 0: random RND, 1: ramp, 2: LFSR from current lfsr state
   task automatic run_stream(input logic [7:0] v, input logic [15:0] len, input int mode,
                             output int ones);
      int         d0;
      int         vc0;
      logic [7:0] r;
      d0    = done_cnt;
      vc0   = valid_cnt;
      ones  = 0;
      start = 1'b1;
      value = v;
      length = len;
      @(posedge trig); #1;
      start  = 1'b0;
      value  = 8'($urandom);
      length = 16'($urandom);
      check("busy_after_start", {31'd0, busy}, {31'd0, (len != 16'd0)});
      check("ones_cleared", {16'd0, ones_cnt}, 32'd0);
      for (int i = 0; i < int'(len); i++) begin
         if (mode == 1) r = 8'(i);
         else if (mode == 2) begin
            r = lfsr;
            lfsr = lfsr_step(lfsr);
         end else r = 8'($urandom_range(0, 255));
         rnd = r;
         exp_q.push_back(r < v);
         ones += int'(r < v);
         @(posedge trig); #1;
      end
      check("done_early", {31'd0, done}, 32'd0);
      check("busy_last", {31'd0, busy}, 32'd0);
      @(posedge trig); #1;
      check("done_pulse", {31'd0, done}, 32'd1);
      check("valid_at_done", {31'd0, sn_valid}, 32'd0);
      check("ones_at_done", {16'd0, ones_cnt}, ones);
      @(posedge trig); #1;
      check("done_drop", {31'd0, done}, 32'd0);
      check("ones_stable", {16'd0, ones_cnt}, ones);
      check("done_count", done_cnt - d0, 32'd1);
      check("valid_count", valid_cnt - vc0, {16'd0, len});
      check("queue_empty", exp_q.size(), 32'd0);
   endtask

   initial begin
      int         ones;
      int         ones1;
      int         d0;
      int         mism;
      logic [7:0] r;
      logic [15:0] dut_ones1;

      rst_n = 1'b0; start = 1'b0; value = 8'd0; length = 16'd0; rnd = 8'd0;
      lfsr = 8'hA5;
      repeat (3) @(posedge trig);
      #1;
      check("rst_sn", {31'd0, sn}, 32'd0);
      check("rst_valid", {31'd0, sn_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_ones", {16'd0, ones_cnt}, 32'd0);
      check("rst_state", {30'd0, dbg_state}, 32'd0);
      @(negedge trig);
      rst_n = 1'b1;
      @(posedge trig); #1;

      // VALUE=0: no ones at all
      run_stream(8'd0, 16'd100, 0, ones);
      check("zero_ones", {16'd0, ones_cnt}, 32'd0);

      // ramp with half scale
      run_stream(8'd128, 16'd256, 1, ones);
      check("ramp128_ones", {16'd0, ones_cnt}, 32'd128);

      // ramp with full scale: only RND=255 yields 0
      run_stream(8'd255, 16'd256, 1, ones);
      check("ramp255_ones", {16'd0, ones_cnt}, 32'd255);

      // zero-length stream
      run_stream(8'd99, 16'd0, 0, ones);
      check("len0_ones", {16'd0, ones_cnt}, 32'd0);

      // mid-stream restart attempt, then asynchronous reset
      d0 = done_cnt;
      start = 1'b1; value = 8'd200; length = 16'd50;
      @(posedge trig); #1;
      start = 1'b0;
      ones = 0;
      for (int i = 0; i < 30; i++) begin
         r = 8'($urandom_range(0, 255));
         rnd = r;
         exp_q.push_back(r < 8'd200);
         ones += int'(r < 8'd200);
         if (i == 10) begin
            start = 1'b1; value = 8'd0; length = 16'd3;
         end else start = 1'b0;
         @(posedge trig); #1;
      end
      @(negedge trig); #1;
      check("abandon_busy", {31'd0, busy}, 32'd1);
      check("abandon_valid", {31'd0, sn_valid}, 32'd1);
      check("abandon_ones", {16'd0, ones_cnt}, ones);
      rst_n = 1'b0;
      #1;
      check("async_sn", {31'd0, sn}, 32'd0);
      check("async_valid", {31'd0, sn_valid}, 32'd0);
      check("async_busy", {31'd0, busy}, 32'd0);
      check("async_done", {31'd0, done}, 32'd0);
      check("async_ones", {16'd0, ones_cnt}, 32'd0);
      check("async_state", {30'd0, dbg_state}, 32'd0);
      check("abandon_queue", exp_q.size(), 32'd0);
      repeat (3) @(posedge trig);
      #3;
      rst_n = 1'b1;
      repeat (4) @(posedge trig);
      #1;
      check("no_done_after_rst", done_cnt - d0, 32'd0);
      run_stream(8'd77, 16'd5, 0, ones);

      // LFSR-driven stream and its repeat with the same seed
      lfsr = 8'hA5;
      sn_log.delete();
      rec = 1'b1;
      run_stream(8'd64, 16'd1000, 2, ones1);
      rec = 1'b0;
      dut_ones1 = ones_cnt;
      check("lfsr_range", {31'd0, (ones_cnt >= 16'd210 && ones_cnt <= 16'd290)}, 32'd1);
      sn_ref = sn_log;
      lfsr = 8'hA5;
      sn_log.delete();
      rec = 1'b1;
      run_stream(8'd64, 16'd1000, 2, ones);
      rec = 1'b0;
      check("lfsr_repeat_ones", {16'd0, ones_cnt}, {16'd0, dut_ones1});
      check("lfsr_repeat_model", ones, ones1);
      check("lfsr_log_len", sn_log.size(), sn_ref.size());
      mism = 0;
      for (int i = 0; i < sn_log.size() && i < sn_ref.size(); i++)
         if (sn_log[i] !== sn_ref[i]) mism++;
      check("lfsr_repeat_seq", mism, 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/stoch_num_gen.md
Name: stoch_num_gen

Overview:
- Converts a binary operand into a stochastic bitstream of programmable length.
- Each cycle it compares the held operand against a random word from an upstream LFSR: it emits 1 when the random word is strictly less than the operand.
- Sits directly downstream of the LFSR random source. It feeds the stochastic neuron/multiplier fabric.
- Also counts emitted ones so the stream can be self-checked or converted back to binary.

Parameters:
- WIDTH, 8, width of the operand and of the random word.
- LEN_W, 16, width of the stream-length field and of the ones counter.

Ports:
- TRIG  input  1  clock, rising edge; the same clock that shifts the LFSR.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request a new stream; sampled only in IDLE.
- VALUE  input  WIDTH  operand; stream probability is VALUE/2^WIDTH.
- LENGTH  input  LEN_W  number of stream bits to emit.
- RND  input  WIDTH  random word from the LFSR; a new word every TRIG edge.
- SN  output  1  stochastic bit.
- SN_VALID  output  1  SN is a stream bit this cycle.
- BUSY  output  1  high while in RUN.
- DONE  output  1  one-cycle pulse at end of stream.
- ONES_CNT  output  LEN_W  count of 1s emitted in the current or last stream.

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE.
  - SN=0, SN_VALID=0, BUSY=0, DONE=0, ONES_CNT=0.
  - Internal val_q=0, cnt=0.
  - Reset takes effect immediately, including mid-stream. The stream in progress is abandoned with no DONE pulse.
- All registers update on the rising edge of TRIG. All outputs are registered.
- State machine: IDLE, RUN, FIN.
- IDLE:
  - Edge k with START=1 latches val_q<=VALUE, cnt<=LENGTH, and clears ONES_CNT to 0.
  - If LENGTH!=0, go to RUN and set BUSY=1.
  - If LENGTH==0, go to FIN directly; no stream bits are emitted.
  - START=0 keeps the block in IDLE with all outputs held. ONES_CNT keeps its last value.
- RUN, each edge:
  - SN<=(RND<val_q), unsigned compare.
  - SN_VALID<=1.
  - cnt<=cnt-1.
  - ONES_CNT<=ONES_CNT+(RND<val_q).
  - When cnt==1 at the edge, that bit is the last one. Next state is FIN and BUSY<=0.
- FIN:
  - SN_VALID<=0, SN<=0, DONE<=1 for exactly one cycle.
  - Next state is IDLE. DONE<=0 on the following edge.
- Latency: START sampled at edge k.
  - Stream bits appear after edges k+1 .. k+LENGTH.
  - DONE is high after edge k+LENGTH+1.
  - ONES_CNT is final and stable from the edge at which DONE rises until the next accepted START.
- START in RUN or FIN is ignored, with no queuing. VALUE and LENGTH are don't-care outside the START edge.
- Boundary cases:
  - VALUE=0 gives all-zero SN.
  - VALUE=2^WIDTH-1 gives 1 for every RND except RND=2^WIDTH-1.
  - LENGTH=2^LEN_W-1 is legal.
  - ONES_CNT cannot overflow because ONES_CNT<=LENGTH.
- Back-to-back: START may be asserted during the FIN cycle. It is ignored there and accepted at the first IDLE edge, giving at least one idle cycle between streams.

Test Plan:
- Reset, then START with VALUE=0 and LENGTH=100, any RND.
  - Required: SN=0 for all 100 valid bits.
  - Required: SN_VALID high for exactly 100 cycles, then DONE pulses once, ONES_CNT=0.
- Bench drives RND as a ramp 0..255, one value per edge; START with VALUE=128, LENGTH=256.
  - Required: SN=1 for RND 0..127 and 0 for RND 128..255; ONES_CNT=128 at DONE.
- Same ramp with VALUE=255, LENGTH=256.
  - Required: ONES_CNT=255; SN=0 only on the bit where RND=255.
- START with LENGTH=0.
  - Required: SN_VALID never rises, BUSY stays 0, DONE is high after edge k+1 for one cycle, ONES_CNT=0.
- START with VALUE=200, LENGTH=50; pulse START again at cycle 10 of the stream; drop RESET low at cycle 30.
  - Required: the second START has no effect.
  - Required: at reset, all outputs go to 0 immediately and no DONE pulse occurs.
  - Required: after release, a fresh START with LENGTH=5 completes normally.
- LFSR connected, seed 8'hA5, VALUE=64, LENGTH=1000.
  - Required: ONES_CNT is within 250±40.
  - Required: repeating the run with the same seed gives an identical ONES_CNT and an identical SN sequence.
